// File: rtl/kij_sequencer.sv
// Pass sequencer for the systolic core: fetches and loads weights, streams
// activations, executes, then drains the output FIFO to psum memory, once per kernel position.
module kij_sequencer #(
    parameter int unsigned col     = 8,
    parameter int unsigned row     = 8,
    parameter int unsigned len_nij = 36,
    parameter int unsigned len_kij = 9,
    parameter logic [10:0] w_base  = 11'd1024,
    parameter logic [10:0] a_base  = 11'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij
);

    localparam int unsigned TW      = 16;
    localparam int unsigned WF_LEN  = 2 * col + 1;
    localparam int unsigned WL_LEN  = row + col;
    localparam int unsigned WD_LEN  = col;
    localparam int unsigned GAP_LEN = 11;
    localparam int unsigned AF_LEN  = 2 * len_nij + 1;
    localparam int unsigned EX_LEN  = 2 * len_nij + row + col;
    localparam int unsigned OR_LEN  = len_nij;

    // Both memories disabled and write-protected; everything else low.
    localparam logic [33:0] IDLE_WORD = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

    typedef enum logic [3:0] {
        IDLE, W_FETCH, W_LOAD, W_DRAIN, GAP, A_FETCH, EXEC, OF_WAIT, OF_RD, NEXT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [3:0]      kij_d;
    logic            busy_d, done_d;
    logic [33:0]     inst_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            kij     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            inst    <= IDLE_WORD;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            kij     <= kij_d;
            busy    <= busy_d;
            done    <= done_d;
            inst    <= inst_d;
        end
    end

    // Next state, then the instruction word for that next state so inst lines up with state_q.
    always_comb begin
        state_d = state_q;
        t_d     = t_q + TW'(1);
        kij_d   = kij;
        busy_d  = busy;
        done_d  = 1'b0;
        inst_d  = IDLE_WORD;

        case (state_q)
            IDLE: begin
                t_d = '0;
                if (start) begin
                    state_d = W_FETCH;
                    kij_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            W_FETCH: if (t_q == TW'(WF_LEN - 1)) begin state_d = W_LOAD;  t_d = '0; end
            W_LOAD:  if (t_q == TW'(WL_LEN - 1)) begin state_d = W_DRAIN; t_d = '0; end
            W_DRAIN: if (t_q == TW'(WD_LEN - 1)) begin state_d = GAP;     t_d = '0; end
            GAP:     if (t_q == TW'(GAP_LEN - 1)) begin state_d = A_FETCH; t_d = '0; end
            A_FETCH: if (t_q == TW'(AF_LEN - 1)) begin state_d = EXEC;    t_d = '0; end
            EXEC:    if (t_q == TW'(EX_LEN - 1)) begin state_d = OF_WAIT; t_d = '0; end
            OF_WAIT: begin
                t_d = '0;
                if (ofifo_valid) state_d = OF_RD;
            end
            OF_RD:   if (t_q == TW'(OR_LEN - 1)) begin state_d = NEXT;    t_d = '0; end
            NEXT: begin
                t_d = '0;
                if (kij < 4'(len_kij - 1)) begin
                    kij_d   = kij + 4'd1;
                    state_d = W_FETCH;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase

        case (state_d)
            W_FETCH: begin
                inst_d[19]   = 1'b0;
                inst_d[5]    = 1'b1;
                inst_d[17:7] = 11'(w_base + 11'(t_d));
            end
            W_LOAD: begin
                inst_d[4] = 1'b1;
                inst_d[0] = 1'b1;
            end
            W_DRAIN: inst_d[0] = 1'b1;
            A_FETCH: begin
                inst_d[19]   = 1'b0;
                inst_d[2]    = 1'b1;
                inst_d[17:7] = 11'(a_base + 11'(t_d));
            end
            EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            OF_RD: begin
                inst_d[6]     = 1'b1;
                inst_d[32]    = 1'b0;
                inst_d[31]    = 1'b0;
                inst_d[30:20] = 11'(len_nij * kij_d + t_d);
            end
            default: inst_d = IDLE_WORD;
        endcase
    end

endmodule

// File: tb/tb_kij_sequencer.sv
// Scoreboard bench for kij_sequencer: a pass-offset reference model pushes the
// expected output word each cycle; scenario tasks add targeted inline checks.
module tb_kij_sequencer;

    localparam logic [33:0] IDLE_WORD  = 34'h1800C0000;
    localparam int          PASS_CYC   = 251;
    localparam int          PRE_LEN    = 213;
    localparam int          SEG_PRE    = 0;
    localparam int          SEG_WAIT   = 1;
    localparam int          SEG_OFRD   = 2;
    localparam int          SEG_NEXT   = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    kij_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij         (kij)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [33:0] inst;
        logic        busy;
        logic        done;
        logic [3:0]  kij;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   busy_cycles = 0;
    int   done_cnt    = 0;

    bit   m_active = 1'b0;
    int   m_kij    = 0;
    int   m_seg    = SEG_PRE;
    int   m_p      = 0;
    int   m_q      = 0;

    // Expected word from the position inside a pass, assembled field by field.
    function automatic logic [33:0] exp_inst(input int seg, input int p, input int q, input int k);
        logic        cenp, wenp, cenx, wenx;
        logic [10:0] ap, ax;
        logic        ofr, ifw, ifr, l0r, l0w, ex, ld;
        cenp = 1'b1; wenp = 1'b1; cenx = 1'b1; wenx = 1'b1;
        ap = '0; ax = '0;
        ofr = 0; ifw = 0; ifr = 0; l0r = 0; l0w = 0; ex = 0; ld = 0;
        if (seg == SEG_PRE) begin
            if (p < 17) begin
                cenx = 1'b0; ifw = 1'b1; ax = 11'(1024 + p);
            end else if (p < 33) begin
                ifr = 1'b1; ld = 1'b1;
            end else if (p < 41) begin
                ld = 1'b1;
            end else if (p < 52) begin
                ld = 1'b0;
            end else if (p < 125) begin
                cenx = 1'b0; l0w = 1'b1; ax = 11'(p - 52);
            end else begin
                l0r = 1'b1; ex = 1'b1;
            end
        end else if (seg == SEG_OFRD) begin
            ofr = 1'b1; cenp = 1'b0; wenp = 1'b0; ap = 11'(36 * k + q);
        end
        return {1'b0, cenp, wenp, ap, cenx, wenx, ax, ofr, ifw, ifr, l0r, l0w, ex, ld};
    endfunction

    task automatic model_step();
        exp_t e;
        e.done = 1'b0;
        if (reset) begin
            m_active = 1'b0; m_kij = 0; m_seg = SEG_PRE; m_p = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_kij = 0; m_seg = SEG_PRE; m_p = 0;
            end
        end else begin
            case (m_seg)
                SEG_PRE: begin
                    m_p++;
                    if (m_p == PRE_LEN) m_seg = SEG_WAIT;
                end
                SEG_WAIT: if (ofifo_valid) begin m_seg = SEG_OFRD; m_q = 0; end
                SEG_OFRD: begin
                    m_q++;
                    if (m_q == 36) m_seg = SEG_NEXT;
                end
                default: begin
                    if (m_kij < 8) begin
                        m_kij++; m_seg = SEG_PRE; m_p = 0;
                    end else begin
                        m_active = 1'b0; e.done = 1'b1;
                    end
                end
            endcase
        end
        e.busy = m_active;
        e.kij  = 4'(m_kij);
        e.inst = m_active ? exp_inst(m_seg, m_p, m_q, m_kij) : IDLE_WORD;
        sb_q.push_back(e);
    endtask

    // One clock: model predicts, DUT advances, then scoreboard and exclusivity checks.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        vectors++;
        if ({inst, busy, done, kij} !== e) begin
            miscompares++;
            $display("FAIL scoreboard @%0t: got inst=%h busy=%b done=%b kij=%0d, want inst=%h busy=%b done=%b kij=%0d",
                     $time, inst, busy, done, kij, e.inst, e.busy, e.done, e.kij);
        end
        vectors++;
        if (inst[18] !== 1'b1 || (inst[19] === 1'b0 && (inst[5] ^ inst[2]) !== 1'b1)) begin
            miscompares++;
            $display("FAIL xmem_exclusive @%0t: got inst=%h, want WEN_xmem=1 and CEN_xmem=0 only in one fetch phase",
                     $time, inst);
        end
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0 || kij !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got inst=%h busy=%b done=%b kij=%0d, want %h 0 0 0",
                     inst, busy, done, kij, IDLE_WORD);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic run_to_done(input string name);
        int budget;
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            tick();
            budget++;
        end
        vectors++;
        if (done_cnt == 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got no done within %0d cycles, want one done pulse", name, budget);
        end
    endtask

    task automatic test_nominal();
        int pmem_first, pmem_last, pmem_n, xmem_first, xmem_last;
        pmem_first = -1; pmem_last = -1; pmem_n = 0; xmem_first = -1; xmem_last = -1;
        busy_cycles = 0; done_cnt = 0;
        ofifo_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && busy_cycles < 3000) begin
            tick();
            if (kij === 4'd3 && inst[6] === 1'b1) begin
                if (pmem_first < 0) pmem_first = int'(inst[30:20]);
                pmem_last = int'(inst[30:20]);
                pmem_n++;
            end
            if (kij === 4'd3 && inst[5] === 1'b1) begin
                if (xmem_first < 0) xmem_first = int'(inst[17:7]);
                xmem_last = int'(inst[17:7]);
            end
        end
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL nominal_done_count: got %0d, want 1", done_cnt);
        end
        vectors++;
        if (busy_cycles !== 9 * PASS_CYC) begin
            miscompares++;
            $display("FAIL nominal_busy_cycles: got %0d, want %0d", busy_cycles, 9 * PASS_CYC);
        end
        vectors++;
        if (pmem_first !== 108 || pmem_last !== 143 || pmem_n !== 36) begin
            miscompares++;
            $display("FAIL kij3_pmem_range: got %0d..%0d (%0d words), want 108..143 (36 words)",
                     pmem_first, pmem_last, pmem_n);
        end
        vectors++;
        if (xmem_first !== 1024 || xmem_last !== 1040) begin
            miscompares++;
            $display("FAIL kij3_wfetch_range: got %0d..%0d, want 1024..1040", xmem_first, xmem_last);
        end
        vectors++;
        if (busy !== 1'b0 || kij !== 4'd8) begin
            miscompares++;
            $display("FAIL nominal_final: got busy=%b kij=%0d, want busy=0 kij=8", busy, kij);
        end
    endtask

    task automatic test_stall();
        int budget;
        int bad;
        reset = 1'b1; tick(); reset = 1'b0;
        ofifo_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while (m_seg != SEG_WAIT && budget < 400) begin
            tick();
            budget++;
        end
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (inst !== IDLE_WORD || busy !== 1'b1) bad++;
            tick();
        end
        if (inst !== IDLE_WORD) bad++;
        vectors++;
        if (bad != 0 || budget >= 400) begin
            miscompares++;
            $display("FAIL stall_idle: got %0d non-idle cycles (wait reached=%0d), want 0 and 1",
                     bad, budget < 400);
        end
        ofifo_valid = 1'b1;
        tick();
        vectors++;
        if (inst[6] !== 1'b1 || inst[30:20] !== 11'd0 || inst[32:31] !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_release: got inst=%h, want OF_RD word with A_pmem=0", inst);
        end
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic test_midrun_reset();
        int budget;
        reset = 1'b1; tick(); reset = 1'b0;
        ofifo_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while (!(m_kij == 5 && m_seg == SEG_PRE && m_p == 150) && budget < 2000) begin
            tick();
            budget++;
        end
        vectors++;
        if (inst[1] !== 1'b1 || kij !== 4'd5) begin
            miscompares++;
            $display("FAIL midrun_in_exec: got inst=%h kij=%0d, want execute=1 kij=5", inst, kij);
        end
        reset = 1'b1;
        done_cnt = 0;
        tick();
        reset = 1'b0;
        vectors++;
        if (inst !== IDLE_WORD || kij !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: got inst=%h kij=%0d busy=%b done=%b, want %h 0 0 0",
                     inst, kij, busy, done, IDLE_WORD);
        end
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL midrun_no_done: got %0d done pulses, want 0", done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int budget;
        reset = 1'b1; tick(); reset = 1'b0;
        busy_cycles = 0; done_cnt = 0;
        ofifo_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while (!(m_seg == SEG_PRE && m_p == 60) && budget < 200) begin
            tick();
            budget++;
        end
        vectors++;
        if (inst[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_afetch: got inst=%h, want l0_wr=1", inst);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done("start_busy");
        vectors++;
        if (busy_cycles !== 9 * PASS_CYC) begin
            miscompares++;
            $display("FAIL start_busy_cycles: got %0d, want %0d", busy_cycles, 9 * PASS_CYC);
        end
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || inst !== IDLE_WORD) begin
            miscompares++;
            $display("FAIL reset_over_start: got busy=%b inst=%h, want busy=0 inst=%h", busy, inst, IDLE_WORD);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_midrun_reset();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
